shift_bounce_ctrl: RTL

- Upstream controller for the 4-bit load/shift register.
- Drives that register's LOAD, LR_Shift and D so a single one-hot bit bounces end-to-end a programmable number of passes ("ping-pong light"), then clears the register.
- Monitors the register output O through O_FB against an internal position model and flags mismatches.
- Register contract: on each CLK rising edge, LOAD=1 gives O<=D. LOAD=0 shifts one place: LR_Shift=0 toward MSB, LR_Shift=1 toward LSB, zero fill.

---
 rtl/shift_bounce_if.sv | 24 ++
 rtl/shift_bounce_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/shift_bounce_if.sv
// Register-side bus between the bounce controller and the 4-bit load/shift register.
// The controller drives LOAD/LR_Shift/D; the register returns its output on O_FB.
interface shift_bounce_if #(
  parameter int WIDTH = 4
);
  logic             LOAD;
  logic             LR_Shift;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] O_FB;

  modport master (
    output LOAD,
    output LR_Shift,
    output D,
    input  O_FB
  );

  modport slave (
    input  LOAD,
    input  LR_Shift,
    input  D,
    output O_FB
  );
endinterface

// File: rtl/shift_bounce_ctrl.sv
// Ping-pong light controller: loads a one-hot bit into the shift register, bounces it
// end to end for a programmed number of arrivals, clears it, and checks O_FB each cycle.
module shift_bounce_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic                     STOP,
  input  logic [CNT_W-1:0]         PASSES,
  shift_bounce_if.master           reg_if,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [$clog2(WIDTH)-1:0] POS
);

  localparam int PW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_S,
    RUN,
    CLEAR
  } state_t;

  state_t           state;
  logic             load_q;
  logic             lr_q;
  logic [WIDTH-1:0] d_q;
  logic [PW-1:0]    mdl;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] passes_q;

  logic [PW-1:0]    nxt_pos;
  logic             at_hi;
  logic             at_lo;
  logic             arrive;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             last;
  logic [WIDTH-1:0] exp_oh;
  logic             mism;
  logic             chk_en;

  assign reg_if.LOAD     = load_q;
  assign reg_if.LR_Shift = lr_q;
  assign reg_if.D        = d_q;

  // mdl tracks the register's true bit position, even when POS is frozen by STOP
  assign nxt_pos = lr_q ? mdl - 1'b1 : mdl + 1'b1;
  assign at_hi   = nxt_pos == PW'(WIDTH - 1);
  assign at_lo   = nxt_pos == '0;
  assign arrive  = at_hi | at_lo;
  assign cnt_inc = cnt + 1'b1;
  assign cnt_sat = (cnt == '1) ? cnt : cnt_inc;
  assign last    = (passes_q != '0) && (cnt_inc == passes_q);
  assign exp_oh  = WIDTH'(1) << mdl;
  assign mism    = reg_if.O_FB != exp_oh;
  assign chk_en  = (state == RUN) || (state == CLEAR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      load_q   <= 1'b0;
      lr_q     <= 1'b0;
      d_q      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      POS      <= '0;
      mdl      <= '0;
      cnt      <= '0;
      passes_q <= '0;
    end else begin
      DONE <= 1'b0;
      if (chk_en && mism) ERR <= 1'b1;
      unique case (state)
        IDLE: begin
          if (START) begin
            state    <= LOAD_S;
            load_q   <= 1'b1;
            d_q      <= WIDTH'(1);
            lr_q     <= 1'b0;
            BUSY     <= 1'b1;
            ERR      <= 1'b0;
            passes_q <= PASSES;
            cnt      <= '0;
            mdl      <= '0;
            POS      <= '0;
          end
        end
        LOAD_S: begin
          state  <= RUN;
          load_q <= 1'b0;
          d_q    <= '0;
          lr_q   <= 1'b0;
          mdl    <= '0;
          POS    <= '0;
        end
        RUN: begin
          mdl <= nxt_pos;
          if (STOP) begin
            state  <= CLEAR;
            load_q <= 1'b1;
            d_q    <= '0;
          end else begin
            POS <= nxt_pos;
            if (arrive) begin
              lr_q <= at_hi;
              cnt  <= cnt_sat;
              if (last) begin
                state  <= CLEAR;
                load_q <= 1'b1;
                d_q    <= '0;
              end
            end
          end
        end
        CLEAR: begin
          state  <= IDLE;
          load_q <= 1'b0;
          BUSY   <= 1'b0;
          DONE   <= 1'b1;
          POS    <= '0;
          mdl    <= '0;
        end
      endcase
    end
  end

endmodule
